// File: rtl/circ_shift_tap_engine_if.sv
// ---------------------------------------------------------------------------
// circ_shift_tap_engine_if
// Handshake and tap-stream bundle for circ_shift_tap_engine.
// The engine takes the slave view. The controller or testbench takes the
// master view. ap_clk and ap_rst stay plain ports on the engine.
// ---------------------------------------------------------------------------
interface circ_shift_tap_engine_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    localparam int IDX_W = $clog2(DEPTH);

    // ap_ctrl_chain block-level handshake
    logic              ap_start;
    logic              ap_continue;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_idle;

    // sample input
    logic [DATA_W-1:0] in_data;

    // tap output stream with backpressure
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_vld;
    logic              out_ack;

    modport master (
        output ap_start, ap_continue, in_data, out_ack,
        input  ap_ready, ap_done, ap_idle, out_data, out_idx, out_vld
    );

    modport slave (
        input  ap_start, ap_continue, in_data, out_ack,
        output ap_ready, ap_done, ap_idle, out_data, out_idx, out_vld
    );
endinterface

// File: rtl/circ_shift_tap_engine.sv
// ---------------------------------------------------------------------------
// circ_shift_tap_engine
// Each accepted ap_start shifts one sample into a DEPTH-entry circular buffer.
// The engine then streams all DEPTH taps, oldest first, through a 3-stage
// II=1 pipeline:
//   iter0  issues the read address
//   iter1  registers the read data and index
//   iter2  drives out_data/out_idx/out_vld
// A consumer stall (out_vld && !out_ack) freezes the whole pipeline.
//
// Optional feature: define CIRC_SHIFT_TAP_STATS_EN to add the saturating
// stat_txn_cnt and stat_stall_cnt outputs.
// ---------------------------------------------------------------------------
module circ_shift_tap_engine #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    circ_shift_tap_engine_if.slave    bus
`ifdef CIRC_SHIFT_TAP_STATS_EN
    ,
    output logic [31:0]               stat_txn_cnt,
    output logic [31:0]               stat_stall_cnt
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  head;
    logic [DATA_W-1:0] mem [DEPTH];

    // iter0: issue stage
    logic              iter0_en;
    logic [IDX_W-1:0]  i_cnt;
    logic [IDX_W-1:0]  rd_addr;

    // iter1: read-data stage
    logic              iter1_en;
    logic [DATA_W-1:0] iter1_data;
    logic [IDX_W-1:0]  iter1_idx;

    // iter2: output stage
    logic              out_vld_q;
    logic [DATA_W-1:0] out_data_q;
    logic [IDX_W-1:0]  out_idx_q;

    logic              start_acc;
    logic              stall;
    logic              last_xfer;

    assign start_acc = (state == IDLE) && bus.ap_start;
    assign stall     = out_vld_q && !bus.out_ack;

    // head has already advanced past the new sample, so i=0 reads the oldest entry.
    assign rd_addr   = head + i_cnt;

    // The final tap leaves with nothing left behind it in the pipeline.
    assign last_xfer = out_vld_q && bus.out_ack && (out_idx_q == LAST_IDX)
                       && !iter0_en && !iter1_en;

    assign bus.ap_ready = start_acc;
    assign bus.ap_idle  = (state == IDLE);
    assign bus.ap_done  = (state == DONE);
    assign bus.out_vld  = out_vld_q;
    assign bus.out_data = out_data_q;
    assign bus.out_idx  = out_idx_q;

    // Sample buffer: written once per accepted transaction.
    // NOTE: the buffer is cleared on reset because the first DEPTH-1 taps
    // after reset must read as zero. That rules out a plain RAM macro.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (start_acc) begin
            mem[head] <= bus.in_data;
        end
    end

    // Control FSM and the tap pipeline, all held while the consumer stalls.
    // NOTE: state is assigned with <= so every stage samples the pre-edge
    // value of the stage before it. Blocking assignments here would collapse
    // the pipeline.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= IDLE;
            head       <= '0;
            i_cnt      <= '0;
            iter0_en   <= 1'b0;
            iter1_en   <= 1'b0;
            iter1_data <= '0;
            iter1_idx  <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_acc) begin
                        head     <= head + 1'b1;
                        i_cnt    <= '0;
                        iter0_en <= 1'b1;
                        state    <= LOAD_WRITE;
                    end
                end

                LOAD_WRITE: begin
                    if (!stall) begin
                        if (iter0_en) begin
                            iter1_data <= mem[rd_addr];
                            iter1_idx  <= i_cnt;
                            i_cnt      <= i_cnt + 1'b1;
                            if (i_cnt == LAST_IDX) begin
                                iter0_en <= 1'b0;
                            end
                        end
                        iter1_en <= iter0_en;

                        if (iter1_en) begin
                            out_data_q <= iter1_data;
                            out_idx_q  <= iter1_idx;
                        end
                        out_vld_q <= iter1_en;

                        if (last_xfer) begin
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (bus.ap_continue) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef CIRC_SHIFT_TAP_STATS_EN
    // Saturating counters for completed handshakes and stall cycles.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            stat_txn_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if ((state == DONE) && bus.ap_continue && (stat_txn_cnt != '1)) begin
                stat_txn_cnt <= stat_txn_cnt + 32'd1;
            end
            if (stall && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
